mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_MAX, default 255: the maximum number of consecutive unanswered memory-request cycles; 0 disables the timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port run, input, 1 bit: permits issue of a new instruction fetch.
REQ-005 The block SHALL have port ir, input, 32 bits: instruction-register contents, valid from DECODE onward.
REQ-006 The block SHALL have port brtaken, input, 1 bit: branch outcome from the datapath; information only, since the PC mux consumes it directly.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: memory completes the current request this cycle.
REQ-008 The block SHALL have outputs pc_we, ir_we, mem_req, mem_we, reg_we and retire, each 1 bit: datapath strobes.
REQ-009 The block SHALL have outputs state (3 bits), halted (1 bit), fault (2 bits) and instret (32 bits).

Function
REQ-010 State encoding SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; values 5 and 6 SHALL never occur.
REQ-011 Opcode class SHALL come from ir[6:0]: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111; all other opcodes, including SYSTEM 1110011, are illegal.
REQ-012 In FETCH, mem_req SHALL be high when run=1 or a fetch is pending; mem_we=0.
REQ-013 Once mem_req is raised, it SHALL stay high until mem_ready, even if run drops.
REQ-014 In FETCH, when mem_req and mem_ready are both high, ir_we SHALL be 1 in that same cycle and the next state SHALL be DECODE.
REQ-015 DECODE SHALL last exactly 1 cycle: an illegal opcode goes to HALT with fault=01; any legal opcode goes to EXEC.
REQ-016 EXEC SHALL last 1 cycle with these transitions:
- BRANCH: pc_we=1, reg_we=0, then FETCH.
- JAL/JALR: pc_we=1 and reg_we=1, then FETCH.
- LOAD/STORE: MEM.
- OP, OP-IMM, LUI, AUIPC: WB.
REQ-017 In MEM, mem_req=1, with mem_we=1 for STORE and 0 for LOAD.
REQ-018 On mem_ready in MEM, a STORE SHALL assert pc_we and go to FETCH; a LOAD SHALL go to WB.
REQ-019 WB SHALL last 1 cycle with reg_we=1 and pc_we=1, then FETCH.
REQ-020 retire SHALL equal pc_we; instret SHALL increment by 1 on every retire cycle and wrap from 0xFFFFFFFF to 0.
REQ-021 mem_ready SHALL be ignored whenever mem_req=0.
REQ-022 A wait counter SHALL count consecutive cycles with mem_req=1 and mem_ready=0, and clear on mem_ready or on a state change.
REQ-023 If MEM_WAIT_MAX>0 and the wait counter reaches MEM_WAIT_MAX, the next state SHALL be HALT with fault=10.
REQ-024 If mem_ready arrives in the same cycle the counter reaches its limit, mem_ready SHALL win and no fault is raised.
REQ-025 In HALT, all strobes SHALL be 0 and halted=1; state, fault and instret SHALL be frozen until rst.
REQ-026 All strobes SHALL be functions of the registered state plus run, mem_ready and ir only; there SHALL be no other combinational input-to-output path.

Reset
REQ-027 While rst=1, all strobes SHALL be forced to 0.
REQ-028 On the first edge with rst=1: state=FETCH, halted=0, fault=00, instret=0, wait counter=0, pending fetch cleared.
REQ-029 Reset mid-operation (any state, including an outstanding request) SHALL abandon the operation without any pc_we, reg_we or mem_we pulse.

Verification
REQ-030 ADDI 0x00100093 with run=1 and mem_ready 1 cycle after the request -> states FETCH,FETCH,DECODE,EXEC,WB; retire in WB; instret=1.
REQ-031 SW 0x00112023 with mem_ready 3 cycles into MEM -> mem_req=1 and mem_we=1 held 3 cycles; pc_we in the ready cycle; reg_we never asserted.
REQ-032 BEQ 0x00000063 with brtaken=1 -> pc_we=1 and reg_we=0 in EXEC; next state FETCH.
REQ-033 ir=0x00000000 -> HALT from DECODE; fault=01, halted=1, no pc_we; stays in HALT for 20 cycles with run=1.
REQ-034 MEM_WAIT_MAX=4 with mem_ready held 0 from the first fetch -> HALT after 4 request cycles, fault=10.
REQ-035 rst pulsed while a LOAD waits in MEM -> next cycle state=FETCH, all strobes 0, instret=0, fault=00.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for a simple RV32 datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB and raises the datapath strobes.
module mc_sequencer #(
   parameter int unsigned MEM_WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        brtaken,
   input  logic        mem_ready,
   output logic        pc_we,
   output logic        ir_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic        reg_we,
   output logic        retire,
   output logic [2:0]  state,
   output logic        halted,
   output logic [1:0]  fault,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   localparam int unsigned WW =
      (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
   localparam logic [WW-1:0] WAIT_LIM = WW'(MEM_WAIT_MAX);

   localparam logic [1:0] F_NONE    = 2'b00;
   localparam logic [1:0] F_ILLEGAL = 2'b01;
   localparam logic [1:0] F_TIMEOUT = 2'b10;

   state_t        r_state;
   state_t        w_nxt;
   logic          r_pend;
   logic          w_pend_nxt;
   logic [WW-1:0] r_wait;
   logic [WW-1:0] w_wait_p1;
   logic [1:0]    r_fault;
   logic [1:0]    w_fault_nxt;
   logic [31:0]   r_instret;

   logic          w_pc_we;
   logic          w_ir_we;
   logic          w_mem_req;
   logic          w_mem_we;
   logic          w_reg_we;
   logic          w_tmo;

   logic [6:0]    w_opc;
   logic          w_load;
   logic          w_store;
   logic          w_br;
   logic          w_jmp;
   logic          w_alu;
   logic          w_legal;
   logic          w_unused;

   // opcode classification from the low seven IR bits
   assign w_opc   = ir[6:0];
   assign w_load  = (w_opc == 7'b0000011);
   assign w_store = (w_opc == 7'b0100011);
   assign w_br    = (w_opc == 7'b1100011);
   assign w_jmp   = (w_opc == 7'b1101111) | (w_opc == 7'b1100111);
   assign w_alu   = (w_opc == 7'b0010011) | (w_opc == 7'b0110011)
                  | (w_opc == 7'b0110111) | (w_opc == 7'b0010111);
   assign w_legal = w_load | w_store | w_br | w_jmp | w_alu;

   // branch outcome steers the PC mux directly, not the sequencer
   assign w_unused = brtaken ^ (^ir[31:7]);

   // a request that has waited one more cycle would hit the limit
   assign w_wait_p1 = r_wait + 1'b1;
   assign w_tmo     = (MEM_WAIT_MAX != 0) && (w_wait_p1 == WAIT_LIM);

   // next-state and raw strobe decode
   always_comb begin
      w_nxt       = r_state;
      w_fault_nxt = r_fault;
      w_pend_nxt  = 1'b0;
      w_pc_we     = 1'b0;
      w_ir_we     = 1'b0;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_reg_we    = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            w_mem_req = run | r_pend;
            if (w_mem_req) begin
               if (mem_ready) begin
                  w_ir_we = 1'b1;
                  w_nxt   = S_DECODE;
               end else if (w_tmo) begin
                  w_nxt       = S_HALT;
                  w_fault_nxt = F_TIMEOUT;
               end else begin
                  w_pend_nxt = 1'b1;
               end
            end
         end
         S_DECODE: begin
            if (w_legal) begin
               w_nxt = S_EXEC;
            end else begin
               w_nxt       = S_HALT;
               w_fault_nxt = F_ILLEGAL;
            end
         end
         S_EXEC: begin
            if (w_br) begin
               w_pc_we = 1'b1;
               w_nxt   = S_FETCH;
            end else if (w_jmp) begin
               w_pc_we  = 1'b1;
               w_reg_we = 1'b1;
               w_nxt    = S_FETCH;
            end else if (w_load | w_store) begin
               w_nxt = S_MEM;
            end else if (w_alu) begin
               w_nxt = S_WB;
            end else begin
               w_nxt       = S_HALT;
               w_fault_nxt = F_ILLEGAL;
            end
         end
         S_MEM: begin
            w_mem_req = 1'b1;
            w_mem_we  = w_store;
            if (mem_ready) begin
               if (w_store) begin
                  w_pc_we = 1'b1;
                  w_nxt   = S_FETCH;
               end else begin
                  w_nxt = S_WB;
               end
            end else if (w_tmo) begin
               w_nxt       = S_HALT;
               w_fault_nxt = F_TIMEOUT;
            end
         end
         S_WB: begin
            w_pc_we  = 1'b1;
            w_reg_we = 1'b1;
            w_nxt    = S_FETCH;
         end
         S_HALT: begin
            w_nxt = S_HALT;
         end
         default: begin
            w_nxt = S_FETCH;
         end
      endcase
   end

   // state, pending fetch, fault and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_pend    <= 1'b0;
         r_fault   <= F_NONE;
         r_instret <= '0;
      end else begin
         r_state   <= w_nxt;
         r_pend    <= w_pend_nxt;
         r_fault   <= w_fault_nxt;
         r_instret <= r_instret + {31'd0, w_pc_we};
      end
   end

   // consecutive unanswered request cycles within one state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait <= '0;
      end else if ((w_nxt != r_state) || !w_mem_req || mem_ready) begin
         r_wait <= '0;
      end else begin
         r_wait <= w_wait_p1;
      end
   end

   assign pc_we   = w_pc_we   & ~rst;
   assign ir_we   = w_ir_we   & ~rst;
   assign mem_req = w_mem_req & ~rst;
   assign mem_we  = w_mem_we  & ~rst;
   assign reg_we  = w_reg_we  & ~rst;
   assign retire  = pc_we;
   assign state   = r_state;
   assign halted  = (r_state == S_HALT);
   assign fault   = r_fault;
   assign instret = r_instret;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: scenario tests for mc_sequencer.
// Per-cycle expected outputs are queued with the stimulus.
module tb_mc_sequencer;

   localparam logic [31:0] ADDI = 32'h00100093;
   localparam logic [31:0] SW   = 32'h00112023;
   localparam logic [31:0] BEQ  = 32'h00000063;
   localparam logic [31:0] LW   = 32'h00002083;
   localparam logic [31:0] JAL  = 32'h0000006F;
   localparam logic [31:0] ILL  = 32'h00000000;

   // output bits after state: pc_we ir_we mem_req mem_we reg_we retire halted
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] FREQ = 7'b0010000;
   localparam logic [6:0] FRDY = 7'b0110000;
   localparam logic [6:0] WBK  = 7'b1000110;
   localparam logic [6:0] SWT  = 7'b0011000;
   localparam logic [6:0] SRDY = 7'b1011010;
   localparam logic [6:0] BRX  = 7'b1000010;
   localparam logic [6:0] JMPX = 7'b1000110;
   localparam logic [6:0] HLT  = 7'b0000001;

   typedef struct packed {
      logic [2:0]  ctl;
      logic [31:0] ir;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [31:0] ir;
   logic        brtaken;
   logic        mem_ready;
   logic        pc_we;
   logic        ir_we;
   logic        mem_req;
   logic        mem_we;
   logic        reg_we;
   logic        retire;
   logic [2:0]  state;
   logic        halted;
   logic [1:0]  fault;
   logic [31:0] instret;

   stim_t       stim_q[$];
   logic [9:0]  exp_q[$];
   logic [9:0]  got_q[$];
   int          n_chk = 0;
   int          n_fail = 0;

   mc_sequencer #(.MEM_WAIT_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .ir        (ir),
      .brtaken   (brtaken),
      .mem_ready (mem_ready),
      .pc_we     (pc_we),
      .ir_we     (ir_we),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .reg_we    (reg_we),
      .retire    (retire),
      .state     (state),
      .halted    (halted),
      .fault     (fault),
      .instret   (instret)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] obs();
      return {state, pc_we, ir_we, mem_req, mem_we, reg_we, retire, halted};
   endfunction

   // ctl = {rst, run, mem_ready}
   task automatic push(input logic [2:0] c, input logic [31:0] i,
                       input logic [9:0] e);
      stim_q.push_back('{c, i});
      exp_q.push_back(e);
   endtask

   task automatic run_q();
      got_q.delete();
      foreach (stim_q[k]) begin
         {rst, run, mem_ready} = stim_q[k].ctl;
         ir = stim_q[k].ir;
         @(negedge clk);
         got_q.push_back(obs());
         @(posedge clk);
         #1;
      end
      stim_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      run = 1'b1;
      mem_ready = 1'b1;
      ir = ADDI;
      brtaken = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_chk++;
      if (obs() !== {3'd0, NONE}) begin
         n_fail++;
         $display("FAIL reset_out: got %h want %h", obs(), {3'd0, NONE});
      end
      n_chk++;
      if (fault !== 2'b00 || instret !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_regs: fault %b instret %0d want 0/0",
                  fault, instret);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      run = 1'b0;
      mem_ready = 1'b0;
   endtask

   task automatic test_addi();
      logic [9:0] e, g;
      int k = 0;
      push(3'b010, ADDI, {3'd0, FREQ});
      push(3'b001, ADDI, {3'd0, FRDY});
      push(3'b000, ADDI, {3'd1, NONE});
      push(3'b000, ADDI, {3'd2, NONE});
      push(3'b000, ADDI, {3'd4, WBK});
      push(3'b001, ADDI, {3'd0, NONE});
      push(3'b001, ADDI, {3'd0, NONE});
      run_q();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL addi step %0d: got %h want %h", k, g, e);
         end
         k++;
      end
      n_chk++;
      if (instret !== 32'd1) begin
         n_fail++;
         $display("FAIL addi_instret: got %0d want 1", instret);
      end
   endtask

   task automatic test_sw();
      logic [9:0] e, g;
      int k = 0;
      push(3'b011, SW, {3'd0, FRDY});
      push(3'b000, SW, {3'd1, NONE});
      push(3'b000, SW, {3'd2, NONE});
      push(3'b000, SW, {3'd3, SWT});
      push(3'b000, SW, {3'd3, SWT});
      push(3'b001, SW, {3'd3, SRDY});
      push(3'b000, SW, {3'd0, NONE});
      run_q();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL sw step %0d: got %h want %h", k, g, e);
         end
         k++;
      end
      n_chk++;
      if (instret !== 32'd2) begin
         n_fail++;
         $display("FAIL sw_instret: got %0d want 2", instret);
      end
   endtask

   task automatic test_beq();
      logic [9:0] e, g;
      int k = 0;
      brtaken = 1'b1;
      push(3'b011, BEQ, {3'd0, FRDY});
      push(3'b000, BEQ, {3'd1, NONE});
      push(3'b000, BEQ, {3'd2, BRX});
      push(3'b000, BEQ, {3'd0, NONE});
      run_q();
      brtaken = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL beq step %0d: got %h want %h", k, g, e);
         end
         k++;
      end
      n_chk++;
      if (instret !== 32'd3) begin
         n_fail++;
         $display("FAIL beq_instret: got %0d want 3", instret);
      end
   endtask

   task automatic test_load_wait_limit();
      logic [9:0] e, g;
      int k = 0;
      push(3'b011, LW, {3'd0, FRDY});
      push(3'b000, LW, {3'd1, NONE});
      push(3'b000, LW, {3'd2, NONE});
      push(3'b000, LW, {3'd3, FREQ});
      push(3'b000, LW, {3'd3, FREQ});
      push(3'b000, LW, {3'd3, FREQ});
      push(3'b001, LW, {3'd3, FREQ});
      push(3'b000, LW, {3'd4, WBK});
      push(3'b000, LW, {3'd0, NONE});
      run_q();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL lw_limit step %0d: got %h want %h", k, g, e);
         end
         k++;
      end
      n_chk++;
      if (instret !== 32'd4 || fault !== 2'b00) begin
         n_fail++;
         $display("FAIL lw_limit_regs: instret %0d fault %b want 4/00",
                  instret, fault);
      end
   endtask

   task automatic test_jal();
      logic [9:0] e, g;
      int k = 0;
      push(3'b011, JAL, {3'd0, FRDY});
      push(3'b000, JAL, {3'd1, NONE});
      push(3'b000, JAL, {3'd2, JMPX});
      push(3'b000, JAL, {3'd0, NONE});
      run_q();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL jal step %0d: got %h want %h", k, g, e);
         end
         k++;
      end
      n_chk++;
      if (instret !== 32'd5) begin
         n_fail++;
         $display("FAIL jal_instret: got %0d want 5", instret);
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] e, g;
      int k = 0;
      push(3'b011, LW, {3'd0, FRDY});
      push(3'b000, LW, {3'd1, NONE});
      push(3'b000, LW, {3'd2, NONE});
      push(3'b000, LW, {3'd3, FREQ});
      push(3'b111, LW, {3'd3, NONE});
      push(3'b000, LW, {3'd0, NONE});
      run_q();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL rst_mid step %0d: got %h want %h", k, g, e);
         end
         k++;
      end
      n_chk++;
      if (instret !== 32'd0 || fault !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_mid_regs: instret %0d fault %b want 0/00",
                  instret, fault);
      end
   endtask

   task automatic test_illegal();
      logic [9:0] e, g;
      int k = 0;
      push(3'b011, ILL, {3'd0, FRDY});
      push(3'b011, ILL, {3'd1, NONE});
      for (int i = 0; i < 20; i++) push(3'b011, ILL, {3'd7, HLT});
      run_q();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL illegal step %0d: got %h want %h", k, g, e);
         end
         k++;
      end
      n_chk++;
      if (fault !== 2'b01 || instret !== 32'd0) begin
         n_fail++;
         $display("FAIL illegal_regs: fault %b instret %0d want 01/0",
                  fault, instret);
      end
   endtask

   task automatic test_timeout();
      logic [9:0] e, g;
      int k = 0;
      do_reset();
      for (int i = 0; i < 4; i++) push(3'b010, LW, {3'd0, FREQ});
      for (int i = 0; i < 3; i++) push(3'b010, LW, {3'd7, HLT});
      run_q();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL timeout step %0d: got %h want %h", k, g, e);
         end
         k++;
      end
      n_chk++;
      if (fault !== 2'b10) begin
         n_fail++;
         $display("FAIL timeout_fault: got %b want 10", fault);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_sw();
      test_beq();
      test_load_wait_limit();
      test_jal();
      test_reset_mid();
      test_illegal();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
